crc_pkt_arbiter: RTL and testbench

CRC_PKT_ARBITER -- requirements
Module: crc_pkt_arbiter

---
 rtl/crc_pkt_arbiter.sv | 154 +++++++++++++++
 tb/tb_crc_pkt_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_pkt_arbiter.sv
// Round-robin packet arbiter feeding a shared CRC engine, with a tag FIFO
// that maps each returned CRC back to the channel that sent the packet.
module crc_pkt_arbiter #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned DWIDTH    = 512,
  parameter int unsigned CRC_WIDTH = 16,
  parameter int unsigned TAG_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_CH*DWIDTH-1:0]        s_tdata,
  input  logic [N_CH*(DWIDTH/8)-1:0]    s_tkeep,
  input  logic [N_CH-1:0]               s_tlast,
  input  logic [N_CH-1:0]               s_tvalid,
  output logic [N_CH-1:0]               s_tready,
  output logic [DWIDTH-1:0]             eng_din,
  output logic [DWIDTH/8-1:0]           eng_byteEn,
  output logic                          eng_dlast,
  output logic                          eng_flitEn,
  input  logic [CRC_WIDTH-1:0]          eng_crc,
  input  logic                          eng_crc_vld,
  output logic [CRC_WIDTH-1:0]          crc_out,
  output logic [$clog2(N_CH)-1:0]       crc_ch,
  output logic                          crc_vld,
  output logic                          tag_err
);

  localparam int unsigned CH_W  = $clog2(N_CH);
  localparam int unsigned KW    = DWIDTH / 8;
  localparam int unsigned PTR_W = $clog2(TAG_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_nxt;
  logic [CH_W-1:0]   gnt, last_gnt;
  logic [CH_W-1:0]   rr_pick, rr_idx;
  logic              rr_found;
  logic [CH_W-1:0]   tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  tag_cnt;
  logic              tag_full, tag_empty;
  logic              accept, push, pop;

  assign tag_full  = (tag_cnt == CNT_W'(TAG_DEPTH));
  assign tag_empty = (tag_cnt == '0);
  assign accept    = (state == BUSY) && s_tvalid[gnt] && !tag_full;
  assign push      = accept && s_tlast[gnt];
  assign pop       = eng_crc_vld && !tag_empty;

  // Round-robin search starting just after the last granted channel
  always_comb begin
    rr_pick  = '0;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int unsigned i = 1; i <= N_CH; i++) begin
      rr_idx = CH_W'((32'(last_gnt) + i) % N_CH);
      if (!rr_found && s_tvalid[rr_idx]) begin
        rr_found = 1'b1;
        rr_pick  = rr_idx;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: one arbitration bubble, then hold until the packet's tlast
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rr_found) state_nxt = BUSY;
      BUSY:    if (push)     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready only to the granted channel, and only while a tag slot is free
  always_comb begin
    s_tready = '0;
    if (state == BUSY) s_tready[gnt] = !tag_full;
  end

  // Grant and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt      <= '0;
      last_gnt <= CH_W'(N_CH - 1);
    end else begin
      if (state == IDLE && rr_found) gnt <= rr_pick;
      if (push)                      last_gnt <= gnt;
    end
  end

  // Forward accepted flits to the engine; data/byte enables hold otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_din    <= '0;
      eng_byteEn <= '0;
      eng_dlast  <= 1'b0;
      eng_flitEn <= 1'b0;
    end else begin
      eng_flitEn <= accept;
      eng_dlast  <= push;
      if (accept) begin
        eng_din    <= s_tdata[32'(gnt)*DWIDTH +: DWIDTH];
        eng_byteEn <= s_tkeep[32'(gnt)*KW +: KW];
      end
    end
  end

  // Tag FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tag_cnt <= '0;
    end else begin
      if (push) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      if (pop)  rd_ptr <= PTR_W'(rd_ptr + 1'b1);
      case ({push, pop})
        2'b10:   tag_cnt <= CNT_W'(tag_cnt + 1'b1);
        2'b01:   tag_cnt <= CNT_W'(tag_cnt - 1'b1);
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

  // Tag storage, no reset needed since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= gnt;
  end

  // Tagged result and sticky error for results with no outstanding packet
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_out <= '0;
      crc_ch  <= '0;
      crc_vld <= 1'b0;
      tag_err <= 1'b0;
    end else begin
      crc_vld <= pop;
      if (pop) begin
        crc_out <= eng_crc;
        crc_ch  <= tag_mem[rd_ptr];
      end
      if (eng_crc_vld && tag_empty) tag_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_crc_pkt_arbiter.sv
// Randomized scoreboard bench for crc_pkt_arbiter.
module tb_crc_pkt_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 64;
  localparam int unsigned KW = DW / 8;
  localparam int unsigned CW = 16;
  localparam int unsigned TD = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] s_tdata;
  logic [N*KW-1:0] s_tkeep;
  logic [N-1:0]    s_tlast, s_tvalid, s_tready;
  logic [DW-1:0]   eng_din;
  logic [KW-1:0]   eng_byteEn;
  logic            eng_dlast, eng_flitEn;
  logic [CW-1:0]   eng_crc;
  logic            eng_crc_vld;
  logic [CW-1:0]   crc_out;
  logic [1:0]      crc_ch;
  logic            crc_vld, tag_err;

  crc_pkt_arbiter #(.N_CH(N), .DWIDTH(DW), .CRC_WIDTH(CW), .TAG_DEPTH(TD)) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .eng_din(eng_din), .eng_byteEn(eng_byteEn), .eng_dlast(eng_dlast), .eng_flitEn(eng_flitEn),
    .eng_crc(eng_crc), .eng_crc_vld(eng_crc_vld),
    .crc_out(crc_out), .crc_ch(crc_ch), .crc_vld(crc_vld), .tag_err(tag_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [DW-1:0] data; logic [KW-1:0] keep; logic last; } flit_t;
  typedef struct { logic [DW-1:0] data; logic [KW-1:0] keep; logic last; int due; } exp_flit_t;
  typedef struct { logic [CW-1:0] crc; logic [1:0] ch; int due; } exp_res_t;

  flit_t     src_q [N][$];
  int        pos [N];
  exp_flit_t flitq [$];
  exp_res_t  resq [$];
  int        tagq [$];

  // Reference model of the arbitration rules
  bit m_busy, m_err;
  int m_gnt, m_last, m_count;
  bit acc_valid, acc_last;
  int acc_ch;
  int eng_mode;
  bit gaps;

  logic [DW-1:0] hold_din;
  logic [KW-1:0] hold_keep;
  logic [CW-1:0] hold_crc;
  logic [1:0]    hold_ch;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    r = '0;
    if (m_busy && m_count < int'(TD)) r[m_gnt] = 1'b1;
    return r;
  endfunction

  // Predict the next edge from the rules and queue what the DUT must produce
  task automatic model_eval();
    logic [N-1:0] er;
    bit found;
    er = exp_ready();
    chk("s_tready", 64'(s_tready), 64'(er));
    chk("tag_err", 64'(tag_err), 64'(m_err));
    acc_valid = 0;
    if (m_busy && er[m_gnt] && s_tvalid[m_gnt]) begin
      acc_valid = 1;
      acc_ch    = m_gnt;
      acc_last  = s_tlast[m_gnt];
      flitq.push_back('{s_tdata[m_gnt*DW +: DW], s_tkeep[m_gnt*KW +: KW], s_tlast[m_gnt], cyc + 1});
    end
    if (eng_crc_vld) begin
      if (m_count > 0) begin
        resq.push_back('{eng_crc, 2'(tagq.pop_front()), cyc + 1});
        m_count--;
      end else begin
        m_err = 1;
      end
    end
    if (acc_valid && acc_last) begin
      tagq.push_back(m_gnt);
      m_count++;
      m_last = m_gnt;
      m_busy = 0;
    end else if (!m_busy) begin
      found = 0;
      for (int i = 1; i <= int'(N); i++) begin
        int k;
        k = (m_last + i) % int'(N);
        if (!found && s_tvalid[k]) begin
          found  = 1;
          m_gnt  = k;
          m_busy = 1;
        end
      end
    end
  endtask

  task automatic drive_inputs();
    flit_t f;
    for (int c = 0; c < int'(N); c++) begin
      if (src_q[c].size() > pos[c]) begin
        f = src_q[c][pos[c]];
        s_tvalid[c] = (pos[c] > 0) || !gaps || ($urandom_range(2) != 0);
        s_tdata[c*DW +: DW] = f.data;
        s_tkeep[c*KW +: KW] = f.keep;
        s_tlast[c] = f.last;
      end else begin
        s_tvalid[c] = 1'b0;
        s_tlast[c]  = 1'b0;
      end
    end
    eng_crc_vld = (m_count > 0) && ((eng_mode == 2) || (eng_mode == 1 && $urandom_range(2) == 0));
    eng_crc     = CW'($urandom);
  endtask

  task automatic step();
    @(negedge clk);
    if (!rst) model_eval();
    else acc_valid = 0;
    @(posedge clk);
    #1;
    if (acc_valid) begin
      pos[acc_ch]++;
      if (acc_last) begin
        repeat (pos[acc_ch]) src_q[acc_ch].delete(0);
        pos[acc_ch] = 0;
      end
      acc_valid = 0;
    end
    drive_inputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_eng_din", 64'(eng_din), 64'd0);
    chk("rst_eng_byteEn", 64'(eng_byteEn), 64'd0);
    chk("rst_eng_dlast", 64'(eng_dlast), 64'd0);
    chk("rst_eng_flitEn", 64'(eng_flitEn), 64'd0);
    chk("rst_crc_out", 64'(crc_out), 64'd0);
    chk("rst_crc_ch", 64'(crc_ch), 64'd0);
    chk("rst_crc_vld", 64'(crc_vld), 64'd0);
    chk("rst_tag_err", 64'(tag_err), 64'd0);
    flitq.delete(); resq.delete(); tagq.delete();
    m_busy = 0; m_gnt = 0; m_last = int'(N) - 1; m_count = 0; m_err = 0; acc_valid = 0;
    hold_din = '0; hold_keep = '0; hold_crc = '0; hold_ch = '0;
    for (int c = 0; c < int'(N); c++) pos[c] = 0;
    eng_crc_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive_inputs();
  endtask

  task automatic add_pkt(input int c, input int n, input logic [KW-1:0] lastkeep);
    flit_t f;
    for (int i = 0; i < n; i++) begin
      f.data = {$urandom, $urandom};
      f.keep = (i == n - 1) ? lastkeep : '1;
      f.last = (i == n - 1);
      src_q[c].push_back(f);
    end
  endtask

  function automatic bit all_idle();
    bit idle;
    idle = !m_busy && m_count == 0 && flitq.size() == 0 && resq.size() == 0;
    for (int c = 0; c < int'(N); c++) if (src_q[c].size() != 0) idle = 0;
    return idle;
  endfunction

  task automatic run_idle(input int max);
    int g;
    g = 0;
    while (!all_idle() && g < max) begin
      step();
      g++;
    end
    repeat (3) step();
    chk("drain_timeout", 64'(g >= max), 64'd0);
  endtask

  // Monitor: compare every DUT output cycle against the queued expectations
  always @(negedge clk) begin
    if (!rst) begin
      if (flitq.size() > 0 && flitq[0].due == cyc) begin
        exp_flit_t e;
        e = flitq.pop_front();
        chk("eng_flitEn", 64'(eng_flitEn), 64'd1);
        chk("eng_din", 64'(eng_din), 64'(e.data));
        chk("eng_byteEn", 64'(eng_byteEn), 64'(e.keep));
        chk("eng_dlast", 64'(eng_dlast), 64'(e.last));
        hold_din  = e.data;
        hold_keep = e.keep;
      end else begin
        chk("eng_flitEn_idle", 64'(eng_flitEn), 64'd0);
        chk("eng_dlast_idle", 64'(eng_dlast), 64'd0);
        chk("eng_din_hold", 64'(eng_din), 64'(hold_din));
        chk("eng_byteEn_hold", 64'(eng_byteEn), 64'(hold_keep));
      end
      if (resq.size() > 0 && resq[0].due == cyc) begin
        exp_res_t r;
        r = resq.pop_front();
        chk("crc_vld", 64'(crc_vld), 64'd1);
        chk("crc_out", 64'(crc_out), 64'(r.crc));
        chk("crc_ch", 64'(crc_ch), 64'(r.ch));
        hold_crc = r.crc;
        hold_ch  = r.ch;
      end else begin
        chk("crc_vld_idle", 64'(crc_vld), 64'd0);
        chk("crc_out_hold", 64'(crc_out), 64'(hold_crc));
        chk("crc_ch_hold", 64'(crc_ch), 64'(hold_ch));
      end
    end
  end

  initial begin
    int gch [$];
    int gcy [$];
    int rr_exp [5];
    int guard;
    rr_exp = '{0, 1, 2, 3, 0};
    rst = 1'b0;
    s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0;
    eng_crc_vld = 1'b0; eng_crc = '0;
    eng_mode = 2; gaps = 0;
    m_busy = 0; m_err = 0; m_gnt = 0; m_last = int'(N) - 1; m_count = 0;
    for (int c = 0; c < int'(N); c++) pos[c] = 0;
    #2;
    do_reset();

    // Single channel, short last flit
    add_pkt(2, 3, 8'h0F);
    run_idle(200);

    // Round-robin with all channels busy on 1-flit packets
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < int'(N); c++) add_pkt(c, 1, 8'hFF);
    do_reset();
    guard = 0;
    while (gch.size() < 5 && guard < 100) begin
      step();
      guard++;
      if (s_tready != '0) begin
        for (int c = 0; c < int'(N); c++) if (s_tready[c]) gch.push_back(c);
        gcy.push_back(cyc);
      end
    end
    chk("rr_grants", 64'(gch.size()), 64'd5);
    for (int i = 0; i < gch.size() && i < 5; i++) chk("rr_order", 64'(gch[i]), 64'(rr_exp[i]));
    for (int i = 1; i < gcy.size(); i++) chk("rr_spacing", 64'(gcy[i] - gcy[i-1]), 64'd2);
    run_idle(200);

    // Backpressure from a full tag FIFO
    eng_mode = 0;
    for (int p = 0; p < 3; p++) add_pkt(0, 2, 8'h3F);
    repeat (20) step();
    chk("bp_ready_stalled", 64'(s_tready[0]), 64'd0);
    chk("bp_no_result", 64'(crc_vld), 64'd0);
    eng_crc_vld = 1'b1;
    eng_crc = CW'($urandom);
    step();
    chk("bp_ready_resumed", 64'(s_tready[0]), 64'd1);
    eng_mode = 1;
    run_idle(300);

    // Random traffic with gaps and random engine latency
    gaps = 1;
    for (int p = 0; p < 40; p++)
      add_pkt(int'($urandom_range(N - 1)), int'($urandom_range(4, 1)), KW'($urandom_range(255, 1)));
    run_idle(3000);
    gaps = 0;

    // Result with no outstanding packet
    eng_crc_vld = 1'b1;
    eng_crc = CW'($urandom);
    repeat (4) step();
    chk("spur_tag_err", 64'(tag_err), 64'd1);
    chk("spur_crc_vld", 64'(crc_vld), 64'd0);

    // Reset in the middle of a packet
    add_pkt(1, 3, 8'hFF);
    guard = 0;
    while (pos[1] != 1 && guard < 50) begin
      step();
      guard++;
    end
    chk("rst_setup_timeout", 64'(guard >= 50), 64'd0);
    add_pkt(0, 1, 8'h01);
    do_reset();
    guard = 0;
    while (s_tready == '0 && guard < 50) begin
      step();
      guard++;
    end
    chk("first_gnt_after_rst", 64'(s_tready), 64'd1);
    run_idle(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
